control_fsm: RTL

Multi-cycle, parametrised control unit for the 8-bit single-issue CPU. It accepts one instruction opcode at a time over a valid/ready handshake and sequences it through execute, data-memory wait and write-back. It drives the ALU, register-file and memory control lines, resolves jumps and branches, and traps on illegal opcodes or memory timeouts. It sits between instruction fetch (PC/instruction memory) and the datapath (register file, ALU, data memory).

---
 rtl/control_fsm.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the 8-bit single-issue CPU.
// Accepts one opcode per valid/ready handshake, sequences it through
// EXEC / MEM_WAIT / WB, drives datapath strobes and traps on illegal
// opcodes or data-memory timeouts. Strobes are registered from the next
// state; BRANCH_TAKEN additionally gates the live ALU zero flag.
module control_fsm #(
  parameter int OPCODE_WIDTH = 8,
  parameter int ALUOP_WIDTH  = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [OPCODE_WIDTH-1:0] OPCODE,
  input  logic                    INSTR_VALID,
  output logic                    INSTR_READY,
  input  logic                    ZERO,
  input  logic                    BUSYWAIT,
  output logic                    IMM,
  output logic                    SIGN,
  output logic [ALUOP_WIDTH-1:0]  ALUOP,
  output logic                    WRITEENABLE,
  output logic                    MEMREAD,
  output logic                    MEMWRITE,
  output logic                    JUMP,
  output logic                    BRANCH_TAKEN,
  output logic                    FAULT,
  output logic [1:0]              FAULT_CODE,
  output logic [CNT_WIDTH-1:0]    RETIRED
);

  typedef enum logic [2:0] {
    DECODE   = 3'd0,
    EXEC     = 3'd1,
    MEM_WAIT = 3'd2,
    WB       = 3'd3,
    TRAP     = 3'd4
  } state_t;

  localparam logic [3:0] OP_LOADI = 4'd0;
  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_J     = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_LWD   = 4'd8;
  localparam logic [3:0] OP_LWI   = 4'd9;
  localparam logic [3:0] OP_SWD   = 4'd10;
  localparam logic [3:0] OP_SWI   = 4'd11;

  localparam logic [ALUOP_WIDTH-1:0] ALU_FWD = ALUOP_WIDTH'(2'd0);
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD = ALUOP_WIDTH'(2'd1);
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND = ALUOP_WIDTH'(2'd2);
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR  = ALUOP_WIDTH'(2'd3);

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // The trap edge samples the MEM_TIMEOUT-th consecutive busy cycle, i.e.
  // the one seen while the counter already holds MEM_TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic                   ready;
    logic                   imm;
    logic                   sign;
    logic [ALUOP_WIDTH-1:0] aluop;
    logic                   we;
    logic                   mem_read;
    logic                   mem_write;
    logic                   jump;
    logic                   br_sel;
    logic                   fault;
  } ctl_t;

  // Opcodes above 11 (any nonzero upper bit included) are illegal.
  function automatic logic is_illegal(input logic [OPCODE_WIDTH-1:0] op);
    return (op > OPCODE_WIDTH'(4'd11));
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LWD) || (op == OP_LWI);
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return (op >= OP_LWD);
  endfunction

  // Control word for a given state and latched opcode.
  function automatic ctl_t decode_ctl(input state_t st, input logic [3:0] op);
    ctl_t c;
    c = '0;
    case (st)
      DECODE: c.ready = 1'b1;
      EXEC: begin
        case (op)
          OP_LOADI: begin c.imm = 1'b1; c.aluop = ALU_FWD; c.we = 1'b1; end
          OP_MOV:   begin c.aluop = ALU_FWD; c.we = 1'b1; end
          OP_ADD:   begin c.aluop = ALU_ADD; c.we = 1'b1; end
          OP_SUB:   begin c.sign = 1'b1; c.aluop = ALU_ADD; c.we = 1'b1; end
          OP_AND:   begin c.aluop = ALU_AND; c.we = 1'b1; end
          OP_OR:    begin c.aluop = ALU_OR; c.we = 1'b1; end
          OP_J:     c.jump = 1'b1;
          OP_BEQ:   begin c.sign = 1'b1; c.aluop = ALU_ADD; c.br_sel = 1'b1; end
          OP_LWD:   begin c.aluop = ALU_FWD; c.mem_read = 1'b1; end
          OP_LWI:   begin c.imm = 1'b1; c.aluop = ALU_FWD; c.mem_read = 1'b1; end
          OP_SWD:   begin c.aluop = ALU_FWD; c.mem_write = 1'b1; end
          OP_SWI:   begin c.imm = 1'b1; c.aluop = ALU_FWD; c.mem_write = 1'b1; end
          default:  c = '0;
        endcase
      end
      MEM_WAIT: begin
        // Memory request, operand select and ALU op hold their EXEC values.
        c.imm       = (op == OP_LWI) || (op == OP_SWI);
        c.aluop     = ALU_FWD;
        c.mem_read  = is_load(op);
        c.mem_write = (op == OP_SWD) || (op == OP_SWI);
      end
      WB:      c.we = 1'b1;
      TRAP:    c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [3:0]  opcode_r, opcode_nxt_s;
  logic [7:0]  wait_cnt_r, wait_cnt_nxt_s;
  logic [1:0]  fault_code_r, fault_code_nxt_s;
  logic        retire_s;
  ctl_t        ctl_r;
  logic [CNT_WIDTH-1:0] retired_r;

  // Next-state, opcode latch, wait counter, fault code and retire pulse.
  always_comb begin
    state_nxt_s      = state_r;
    opcode_nxt_s     = opcode_r;
    wait_cnt_nxt_s   = wait_cnt_r;
    fault_code_nxt_s = fault_code_r;
    retire_s         = 1'b0;
    case (state_r)
      DECODE: begin
        if (INSTR_VALID) begin
          opcode_nxt_s = OPCODE[3:0];
          if (is_illegal(OPCODE)) begin
            state_nxt_s      = TRAP;
            fault_code_nxt_s = FC_ILLEGAL;
          end else begin
            state_nxt_s = EXEC;
          end
        end else begin
          state_nxt_s = DECODE;
        end
      end
      EXEC: begin
        wait_cnt_nxt_s = 8'd0;
        if (is_mem(opcode_r)) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = DECODE;
          retire_s    = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (BUSYWAIT) begin
          if (wait_cnt_r >= WAIT_LAST) begin
            state_nxt_s      = TRAP;
            fault_code_nxt_s = FC_TIMEOUT;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
          end
        end else begin
          wait_cnt_nxt_s = 8'd0;
          if (is_load(opcode_r)) begin
            state_nxt_s = WB;
          end else begin
            state_nxt_s = DECODE;
            retire_s    = 1'b1;
          end
        end
      end
      WB: begin
        state_nxt_s = DECODE;
        retire_s    = 1'b1;
      end
      TRAP:    state_nxt_s = TRAP;
      default: state_nxt_s = DECODE;
    endcase
  end

  // State, counters and registered control strobes; reset drops any request.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r      <= DECODE;
      opcode_r     <= 4'd0;
      wait_cnt_r   <= 8'd0;
      fault_code_r <= FC_NONE;
      retired_r    <= '0;
      ctl_r        <= decode_ctl(DECODE, 4'd0);
    end else begin
      state_r      <= state_nxt_s;
      opcode_r     <= opcode_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
      fault_code_r <= fault_code_nxt_s;
      retired_r    <= retired_r + {{(CNT_WIDTH-1){1'b0}}, retire_s};
      ctl_r        <= decode_ctl(state_nxt_s, opcode_nxt_s);
    end
  end

  assign INSTR_READY  = ctl_r.ready;
  assign IMM          = ctl_r.imm;
  assign SIGN         = ctl_r.sign;
  assign ALUOP        = ctl_r.aluop;
  assign WRITEENABLE  = ctl_r.we;
  assign MEMREAD      = ctl_r.mem_read;
  assign MEMWRITE     = ctl_r.mem_write;
  assign JUMP         = ctl_r.jump;
  assign BRANCH_TAKEN = ctl_r.br_sel & ZERO;
  assign FAULT        = ctl_r.fault;
  assign FAULT_CODE   = fault_code_r;
  assign RETIRED      = retired_r;

endmodule
